atm_pin_entry: RTL

- Keypad PIN-collection and verification stage directly upstream of the main ATM controller.
- Collects BCD digits after card insertion and compares them against the card's stored PIN.
- Enforces a limited number of attempts and an inactivity timeout.
- Emits one-cycle verdict pulses (pin_ok / pin_fail / timeout / cancelled) and a card-retain lock level, all consumed by the controller.

---
 rtl/atm_pkg.sv | 14 +
 rtl/atm_timeout_counter.sv | 36 +++
 rtl/atm_pin_entry.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM keypad entry stages.
package atm_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BCD_MAX = 9;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StCheck,
    StLocked
  } pin_state_t;

endpackage

// File: rtl/atm_timeout_counter.sv
// Inactivity timer: counts enabled cycles since the last clear and flags the final cycle.
module atm_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] count_q, count_d;

  assign expired = (count_q == CntW'(TIMEOUT_CYCLES - 1));

  // Holds at the expiry value so the flag stays stable until cleared.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/atm_pin_entry.sv
// Keypad PIN collection and verification with attempt limit, inactivity timeout and card lock.
module atm_pin_entry
  import atm_pkg::*;
#(
  parameter int unsigned PIN_DIGITS     = 4,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  digit_valid,
  input  logic [DIGIT_W-1:0]                    digit,
  input  logic                                  enter,
  input  logic                                  clear,
  input  logic                                  cancel,
  input  logic                                  lock_ack,
  input  logic [DIGIT_W*PIN_DIGITS-1:0]         stored_pin,
  output logic                                  busy,
  output logic                                  pin_ok,
  output logic                                  pin_fail,
  output logic                                  timeout,
  output logic                                  cancelled,
  output logic                                  lock_card,
  output logic [$clog2(MAX_TRIES+1)-1:0]        tries_left,
  output logic [$clog2(PIN_DIGITS+1)-1:0]       digit_count
);

  localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);
  localparam int unsigned CntW   = $clog2(PIN_DIGITS + 1);

  pin_state_t state_q, state_d;
  logic [TriesW-1:0] tries_q, tries_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PIN_DIGITS-1:0][DIGIT_W-1:0] digits_q, digits_d;
  logic ok_q, ok_d, fail_q, fail_d, tmo_q, tmo_d, cancel_q, cancel_d;
  logic busy_q, lock_q;
  logic accepted, expired, digit_ok;

  assign digit_ok = (digit <= DIGIT_W'(BCD_MAX)) && (count_q < CntW'(PIN_DIGITS));

  atm_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state_q != StCollect) || accepted),
    .enable (state_q == StCollect),
    .expired(expired)
  );

  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    count_d  = count_q;
    digits_d = digits_q;
    ok_d     = 1'b0;
    fail_d   = 1'b0;
    tmo_d    = 1'b0;
    cancel_d = 1'b0;
    accepted = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCollect;
          tries_d = TriesW'(MAX_TRIES);
          count_d = '0;
        end
      end
      StCollect: begin
        // Expiry outranks clear and digits but yields to cancel and enter.
        if (cancel) begin
          state_d  = StIdle;
          cancel_d = 1'b1;
          count_d  = '0;
          digits_d = '0;
        end else if (enter) begin
          state_d = StCheck;
        end else if (expired) begin
          state_d = StIdle;
          tmo_d   = 1'b1;
          count_d = '0;
        end else if (clear) begin
          count_d  = '0;
          accepted = 1'b1;
        end else if (digit_valid && digit_ok) begin
          for (int i = 0; i < int'(PIN_DIGITS); i++) begin
            if (count_q == CntW'(i)) digits_d[i] = digit;
          end
          count_d  = count_q + CntW'(1);
          accepted = 1'b1;
        end
      end
      StCheck: begin
        count_d = '0;
        if ((count_q == CntW'(PIN_DIGITS)) && (digits_q == stored_pin)) begin
          state_d = StIdle;
          ok_d    = 1'b1;
          count_d = count_q;
        end else begin
          fail_d  = 1'b1;
          tries_d = (tries_q == '0) ? '0 : tries_q - TriesW'(1);
          state_d = (tries_q <= TriesW'(1)) ? StLocked : StCollect;
        end
      end
      StLocked: begin
        if (lock_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      tries_q  <= TriesW'(MAX_TRIES);
      count_q  <= '0;
      digits_q <= '0;
      ok_q     <= 1'b0;
      fail_q   <= 1'b0;
      tmo_q    <= 1'b0;
      cancel_q <= 1'b0;
      busy_q   <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tries_q  <= tries_d;
      count_q  <= count_d;
      digits_q <= digits_d;
      ok_q     <= ok_d;
      fail_q   <= fail_d;
      tmo_q    <= tmo_d;
      cancel_q <= cancel_d;
      busy_q   <= (state_d != StIdle);
      lock_q   <= (state_d == StLocked);
    end
  end

  assign busy        = busy_q;
  assign pin_ok      = ok_q;
  assign pin_fail    = fail_q;
  assign timeout     = tmo_q;
  assign cancelled   = cancel_q;
  assign lock_card   = lock_q;
  assign tries_left  = tries_q;
  assign digit_count = count_q;

endmodule
